// File: rtl/rand_range_sampler_if.sv
// Request/response bundle between a consumer unit and the range sampler.
// The consumer drives the master side and the sampler implements the slave side.
interface rand_range_sampler_if #(
    parameter int S_WIDTH = 8
);
    logic               req_valid;
    logic [S_WIDTH-1:0] req_limit;
    logic               req_ready;
    logic               rsp_valid;
    logic [S_WIDTH-1:0] rsp_num;
    logic               rsp_fallback;
    logic               rsp_ready;

    modport master (
        output req_valid, req_limit, rsp_ready,
        input  req_ready, rsp_valid, rsp_num, rsp_fallback
    );

    modport slave (
        input  req_valid, req_limit, rsp_ready,
        output req_ready, rsp_valid, rsp_num, rsp_fallback
    );
endinterface

// File: rtl/rand_range_sampler.sv
// Rejection sampler: maps the raw LFSR stream to a uniform integer in [0, limit), with a fallback after MAX_TRIES draws.
// RAND_RANGE_SAMPLER_STATS_EN adds saturating reject/fallback counters; stalls whenever rand_valid_i is low.
module rand_range_sampler #(
    parameter int S_WIDTH   = 8,
    parameter int MAX_TRIES = 4,
    parameter int TRY_WIDTH = 2
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic [S_WIDTH-1:0] rand_num_i,
    input  logic               rand_valid_i,
    rand_range_sampler_if.slave bus
`ifdef RAND_RANGE_SAMPLER_STATS_EN
    ,
    output logic [15:0]        reject_cnt_o,
    output logic [15:0]        fallback_cnt_o
`endif
);
    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SAMPLE = 2'd1;
    localparam logic [1:0] ST_RESP   = 2'd2;

    logic [1:0]           state_q, state_d;
    logic [TRY_WIDTH-1:0] tries_q, tries_d;
    logic [S_WIDTH:0]     lim_q, lim_d;
    logic [S_WIDTH-1:0]   mask_q, mask_d;
    logic [S_WIDTH-1:0]   num_q, num_d;
    logic                 fb_q, fb_d;

    logic [S_WIDTH-1:0]   req_lim_m1;
    logic [S_WIDTH-1:0]   req_mask;
    logic [S_WIDTH-1:0]   cand;
    logic                 cand_ok;
    logic                 last_try;
    logic                 sample_fire;

    // A limit of 0 stands for the full 2^S_WIDTH range, so lim-1 is all ones.
    assign req_lim_m1 = (bus.req_limit == '0) ? '1 : bus.req_limit - 1'b1;

    // Mask bit i is set when lim-1 has any bit at or above i: smallest 2^k-1 covering lim-1.
    always_comb begin
        req_mask = '0;
        for (int i = 0; i < S_WIDTH; i++) begin
            req_mask[i] = |(req_lim_m1 >> i);
        end
    end

    assign cand        = rand_num_i & mask_q;
    assign cand_ok     = {1'b0, cand} < lim_q;
    assign last_try    = (tries_q == TRY_WIDTH'(MAX_TRIES - 1));
    assign sample_fire = (state_q == ST_SAMPLE) && rand_valid_i;

    always_comb begin
        state_d = state_q;
        tries_d = tries_q;
        lim_d   = lim_q;
        mask_d  = mask_q;
        num_d   = num_q;
        fb_d    = fb_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.req_valid) begin
                    lim_d   = (bus.req_limit == '0) ? {1'b1, {S_WIDTH{1'b0}}}
                                                    : {1'b0, bus.req_limit};
                    mask_d  = req_mask;
                    tries_d = '0;
                    state_d = ST_SAMPLE;
                end
            end
            ST_SAMPLE: begin
                if (rand_valid_i) begin
                    if (cand_ok) begin
                        num_d   = cand;
                        fb_d    = 1'b0;
                        state_d = ST_RESP;
                    end else if (last_try) begin
                        // cand <= mask < 2*lim, so a single subtraction lands in range.
                        num_d   = cand - lim_q[S_WIDTH-1:0];
                        fb_d    = 1'b1;
                        state_d = ST_RESP;
                    end else begin
                        tries_d = tries_q + 1'b1;
                    end
                end
            end
            ST_RESP: begin
                if (bus.rsp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            tries_q <= '0;
            lim_q   <= '0;
            mask_q  <= '0;
            num_q   <= '0;
            fb_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            tries_q <= tries_d;
            lim_q   <= lim_d;
            mask_q  <= mask_d;
            num_q   <= num_d;
            fb_q    <= fb_d;
        end
    end

    assign bus.req_ready    = (state_q == ST_IDLE);
    assign bus.rsp_valid    = (state_q == ST_RESP);
    assign bus.rsp_num      = num_q;
    assign bus.rsp_fallback = fb_q;

`ifdef RAND_RANGE_SAMPLER_STATS_EN
    logic [15:0] rej_cnt_q, rej_cnt_d;
    logic [15:0] fb_cnt_q, fb_cnt_d;

    always_comb begin
        rej_cnt_d = rej_cnt_q;
        fb_cnt_d  = fb_cnt_q;
        if (sample_fire && !cand_ok && (rej_cnt_q != '1)) begin
            rej_cnt_d = rej_cnt_q + 1'b1;
        end
        if (sample_fire && !cand_ok && last_try && (fb_cnt_q != '1)) begin
            fb_cnt_d = fb_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rej_cnt_q <= '0;
            fb_cnt_q  <= '0;
        end else begin
            rej_cnt_q <= rej_cnt_d;
            fb_cnt_q  <= fb_cnt_d;
        end
    end

    assign reject_cnt_o   = rej_cnt_q;
    assign fallback_cnt_o = fb_cnt_q;
`else
    logic unused_fire;
    assign unused_fire = sample_fire;
`endif
endmodule

// File: tb/tb_rand_range_sampler.sv
// Bench for rand_range_sampler: directed and random requests, scoreboard-checked by an independent monitor.
// Expected results come from a reference model working on the stream of random words the bench drives.
module tb_rand_range_sampler;
    localparam int MAX_TRIES = 4;

    typedef struct {
        int num;
        int fb;
        int lat;
    } exp_t;

    logic       clk_i = 1'b0;
    logic       rst_i = 1'b1;
    logic [7:0] rand_num_i = '0;
    logic       rand_valid_i = 1'b0;
`ifdef RAND_RANGE_SAMPLER_STATS_EN
    logic [15:0] reject_cnt_o;
    logic [15:0] fallback_cnt_o;
`endif

    rand_range_sampler_if #(.S_WIDTH(8)) bus ();

    rand_range_sampler #(.S_WIDTH(8), .MAX_TRIES(MAX_TRIES), .TRY_WIDTH(2)) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .rand_num_i   (rand_num_i),
        .rand_valid_i (rand_valid_i),
        .bus          (bus)
`ifdef RAND_RANGE_SAMPLER_STATS_EN
        ,
        .reject_cnt_o   (reject_cnt_o),
        .fallback_cnt_o (fallback_cnt_o)
`endif
    );

    always #5 clk_i = ~clk_i;

    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;
    int   acc_cyc = 0;
    int   stall_cnt = 0;
    bit   force_low = 0;
    int   model_rej = 0;
    int   model_fb = 0;
    exp_t exp_q[$];
    int   stim_w[$];
    bit   stim_v[$];

    always @(posedge clk_i) cyc++;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: the first MAX_TRIES usable words are candidates; the first one under
    // the limit wins, otherwise the last candidate minus the limit is returned.
    task automatic model(input int lim_in, output int num, output int fb, output int idx, output int rej);
        int lim, mask, k, used, cand;
        lim  = (lim_in == 0) ? 256 : lim_in;
        k    = 0;
        while (((1 << k) - 1) < lim - 1) k++;
        mask = (1 << k) - 1;
        used = 0; rej = 0; num = -1; fb = 0; idx = stim_w.size();
        for (int i = 0; i < stim_w.size(); i++) begin
            if (stim_v[i]) begin
                cand = stim_w[i] & mask;
                used++;
                if (cand < lim) begin
                    num = cand; fb = 0; idx = i;
                    return;
                end
                rej++;
                if (used == MAX_TRIES) begin
                    num = cand - lim; fb = 1; idx = i;
                    return;
                end
            end
        end
    endtask

    task automatic do_req(input int lim_in);
        exp_t e;
        int   num, fb, idx, rej, n;
        model(lim_in, num, fb, idx, rej);
        e.num = num; e.fb = fb; e.lat = idx + 2;
        exp_q.push_back(e);
        model_rej += rej;
        model_fb  += fb;
        @(posedge clk_i); #1;
        bus.req_valid = 1'b1;
        bus.req_limit = 8'(lim_in);
        n = 0;
        forever begin
            @(negedge clk_i);
            if (bus.req_ready) break;
            if (++n > 200) begin
                chk("req_accept_timeout", 0, 1);
                bus.req_valid = 1'b0;
                return;
            end
        end
        acc_cyc = cyc;
        @(posedge clk_i); #1;
        bus.req_valid = 1'b0;
        bus.req_limit = 8'($urandom);
        for (int i = 0; i < stim_w.size(); i++) begin
            rand_valid_i = stim_v[i];
            rand_num_i   = 8'(stim_w[i]);
            @(posedge clk_i); #1;
        end
        rand_valid_i = 1'($urandom);
        rand_num_i   = 8'($urandom);
    endtask

    task automatic set_stim(input int w0, input int w1, input int w2, input int w3, input int nw);
        int tmp[4];
        tmp = '{w0, w1, w2, w3};
        stim_w.delete(); stim_v.delete();
        for (int i = 0; i < nw; i++) begin
            stim_w.push_back(tmp[i]);
            stim_v.push_back(1'b1);
        end
    endtask

    task automatic wait_idle();
        int n = 0;
        forever begin
            @(negedge clk_i);
            if (exp_q.size() == 0 && !bus.rsp_valid && bus.req_ready) break;
            if (++n > 500) begin
                chk("idle_timeout", 0, 1);
                break;
            end
        end
    endtask

    task automatic check_stats();
`ifdef RAND_RANGE_SAMPLER_STATS_EN
        chk("reject_cnt", int'(reject_cnt_o), model_rej);
        chk("fallback_cnt", int'(fallback_cnt_o), model_fb);
`endif
    endtask

    task automatic check_reset_state(input string tag);
        chk({tag, "_req_ready"}, int'(bus.req_ready), 1);
        chk({tag, "_rsp_valid"}, int'(bus.rsp_valid), 0);
        chk({tag, "_rsp_num"}, int'(bus.rsp_num), 0);
        chk({tag, "_rsp_fb"}, int'(bus.rsp_fallback), 0);
    endtask

    // Consumer: random backpressure, with optional forced stalls.
    initial begin
        bus.rsp_ready = 1'b0;
        forever begin
            @(posedge clk_i); #1;
            if (force_low) bus.rsp_ready = 1'b0;
            else if (stall_cnt > 0 && bus.rsp_valid) begin
                bus.rsp_ready = 1'b0;
                stall_cnt--;
            end else bus.rsp_ready = 1'($urandom_range(0, 1));
        end
    end

    // Monitor: pops the expected response on the first valid cycle and checks it stays put.
    bit   active = 0;
    exp_t cur;
    always @(negedge clk_i) begin
        if (!rst_i) begin
            if (bus.rsp_valid) begin
                if (!active) begin
                    active = 1;
                    if (exp_q.size() == 0) begin
                        chk("unexpected_rsp", 1, 0);
                        cur.num = int'(bus.rsp_num); cur.fb = int'(bus.rsp_fallback);
                    end else begin
                        cur = exp_q.pop_front();
                        chk("rsp_num", int'(bus.rsp_num), cur.num);
                        chk("rsp_fallback", int'(bus.rsp_fallback), cur.fb);
                        chk("rsp_latency", cyc - acc_cyc, cur.lat);
                    end
                end else begin
                    chk("rsp_num_stable", int'(bus.rsp_num), cur.num);
                    chk("rsp_fb_stable", int'(bus.rsp_fallback), cur.fb);
                end
                chk("req_ready_in_rsp", int'(bus.req_ready), 0);
            end else begin
                active = 0;
            end
        end
    end

    initial begin
        int n, nv, sel, lim;
        bus.req_valid = 1'b0;
        bus.req_limit = '0;
        repeat (3) @(posedge clk_i);
        #1 rst_i = 1'b0;
        @(negedge clk_i);
        check_reset_state("reset");
        check_stats();

        set_stim(8'h07, 8'h0E, 8'h03, 0, 3); do_req(6);
        set_stim(8'hFF, 8'hFF, 8'hFF, 8'hFF, 4); do_req(5);
        wait_idle();
        check_stats();
        set_stim(8'hC8, 0, 0, 0, 1); do_req(0);
        set_stim(8'hAB, 0, 0, 0, 1); do_req(1);
        set_stim(8'hF0, 8'h3C, 0, 0, 2); do_req(16);

        stall_cnt = 5;
        stim_w = '{8'hFF, 8'hFF, 8'hFF, 8'h02};
        stim_v = '{1'b0, 1'b0, 1'b0, 1'b1};
        do_req(6);
        wait_idle();
        check_stats();

        // Reset while sampling with the random source stalled.
        @(posedge clk_i); #1;
        bus.req_valid = 1'b1; bus.req_limit = 8'd6; rand_valid_i = 1'b0;
        @(posedge clk_i); #1;
        bus.req_valid = 1'b0;
        @(posedge clk_i); #1;
        rst_i = 1'b1;
        @(posedge clk_i); #1;
        rst_i = 1'b0;
        model_rej = 0; model_fb = 0;
        @(negedge clk_i);
        check_reset_state("rst_sample");

        // Reset while a response is held by a stalled consumer.
        force_low = 1;
        set_stim(8'h55, 0, 0, 0, 1); do_req(0);
        n = 0;
        while (!bus.rsp_valid && n < 50) begin
            @(negedge clk_i); n++;
        end
        chk("rsp_before_rst", int'(bus.rsp_valid), 1);
        @(posedge clk_i); #1;
        rst_i = 1'b1;
        @(posedge clk_i); #1;
        rst_i = 1'b0;
        model_rej = 0; model_fb = 0;
        @(negedge clk_i);
        check_reset_state("rst_resp");
        check_stats();
        force_low = 0;
        set_stim(8'h04, 0, 0, 0, 1); do_req(6);
        wait_idle();

        for (int r = 0; r < 40; r++) begin
            sel = $urandom_range(0, 5);
            case (sel)
                0: lim = 0;
                1: lim = 1;
                2: lim = 1 << $urandom_range(1, 7);
                default: lim = $urandom_range(2, 255);
            endcase
            stim_w.delete(); stim_v.delete();
            nv = 0;
            while (nv < MAX_TRIES) begin
                stim_w.push_back($urandom_range(0, 255));
                stim_v.push_back($urandom_range(0, 3) != 0);
                if (stim_v[stim_v.size() - 1]) nv++;
            end
            do_req(lim);
        end
        wait_idle();
        chk("scoreboard_empty", exp_q.size(), 0);
        check_stats();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
